// File: rtl/anim_frame_sequencer.sv
// Frame sequencer for one 7-segment animation channel.
// A prescaler produces frame ticks; each tick steps the frame index in
// loop, ping-pong, one-shot or hold mode, bounded by a per-animation limit.
// Animation changes arrive on a one-deep valid/ready slot and are applied on
// a frame boundary (a tick), or on the next cycle when the sequence is parked
// (one-shot finished, or hold mode).
module anim_frame_sequencer #(
  parameter int ANI_W         = 6,
  parameter int FRAME_W       = 6,
  parameter int PRESC_W       = 24,
  parameter int DEFAULT_LIMIT = 63
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               pause,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic [1:0]         mode,
  input  logic [ANI_W-1:0]   ani_req,
  input  logic               ani_req_valid,
  output logic               ani_req_ready,
  output logic [ANI_W-1:0]   ani_cur,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_tick,
  output logic               wrap,
  output logic               done
);

  // Sequencing modes.
  localparam logic [1:0] MODE_LOOP    = 2'b00;
  localparam logic [1:0] MODE_PING    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  // Ping-pong direction.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Last valid frame index of each animation.
  function automatic logic [FRAME_W-1:0] lim_of(input logic [ANI_W-1:0] a);
    int unsigned idx;
    int          l;
    idx = {{(32-ANI_W){1'b0}}, a};
    if      (idx == 0)  l = 9;
    else if (idx == 1)  l = 11;
    else if (idx <= 6)  l = 5;
    else if (idx == 7)  l = 1;
    else if (idx <= 9)  l = 3;
    else if (idx <= 14) l = 1;
    else if (idx == 15) l = 3;
    else if (idx == 16) l = 4;
    else if (idx == 17) l = 1;
    else if (idx <= 22) l = 6;
    else if (idx == 23) l = 3;
    else if (idx <= 27) l = 15;
    else if (idx == 28) l = 31;
    else if (idx == 29) l = 3;
    else if (idx == 30) l = 10;
    else if (idx == 31) l = 31;
    else if (idx == 32) l = 4;
    else if (idx == 33) l = 8;
    else if (idx <= 40) l = 4;
    else                l = DEFAULT_LIMIT;
    return l[FRAME_W-1:0];
  endfunction

  logic               dir;
  logic [PRESC_W-1:0] cnt;
  logic [ANI_W-1:0]   pend;
  logic               pend_v;

  logic [FRAME_W-1:0] frame_nxt;
  logic [ANI_W-1:0]   ani_nxt;
  logic               dir_nxt;
  logic [PRESC_W-1:0] cnt_nxt;
  logic [ANI_W-1:0]   pend_nxt;
  logic               pend_v_nxt;
  logic               frame_tick_nxt;
  logic               wrap_nxt;
  logic               done_nxt;

  logic               run;
  logic               tick;
  logic               accept;
  logic               do_switch;
  logic [FRAME_W-1:0] cur_lim;

  // A finished one-shot parks the prescaler until a new animation arrives.
  assign run           = ena && !pause && !done;
  // ">=" rather than "==" so that lowering presc_div below cnt still ticks.
  assign tick          = run && (cnt >= presc_div);
  assign ani_req_ready = !pend_v;
  assign accept        = ani_req_valid && !pend_v;
  assign do_switch     = pend_v && (tick || done || (mode == MODE_HOLD));
  assign cur_lim       = lim_of(ani_cur);

  // Next-state: request capture, animation switch, prescaler and frame stepping.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    frame_nxt      = frame;
    ani_nxt        = ani_cur;
    dir_nxt        = dir;
    cnt_nxt        = cnt;
    pend_nxt       = pend;
    pend_v_nxt     = pend_v;
    frame_tick_nxt = 1'b0;
    wrap_nxt       = 1'b0;
    done_nxt       = done;

    if (accept) begin
      pend_nxt   = ani_req;
      pend_v_nxt = 1'b1;
    end

    if (do_switch) begin
      // A pending switch overrides whatever stepping this tick would have done.
      ani_nxt        = pend;
      frame_nxt      = '0;
      dir_nxt        = DIR_UP;
      done_nxt       = 1'b0;
      cnt_nxt        = '0;
      pend_v_nxt     = 1'b0;
      frame_tick_nxt = 1'b1;
    end else begin
      if (tick)
        cnt_nxt = '0;
      else if (run)
        cnt_nxt = cnt + PRESC_W'(1);

      // Leaving one-shot releases a parked sequence; leaving ping-pong resets direction.
      if (mode != MODE_ONESHOT)
        done_nxt = 1'b0;
      if (mode != MODE_PING)
        dir_nxt = DIR_UP;

      if (tick) begin
        if (frame > cur_lim) begin
          // Out-of-range frame cannot arise normally; recover to frame 0.
          frame_nxt      = '0;
          wrap_nxt       = 1'b1;
          frame_tick_nxt = 1'b1;
        end else begin
          case (mode)
            MODE_LOOP: begin
              frame_tick_nxt = 1'b1;
              if (frame == cur_lim) begin
                frame_nxt = '0;
                wrap_nxt  = 1'b1;
              end else begin
                frame_nxt = frame + FRAME_W'(1);
              end
            end
            MODE_PING: begin
              frame_tick_nxt = 1'b1;
              if (dir == DIR_UP) begin
                if (frame == cur_lim) begin
                  if (cur_lim == '0) begin
                    wrap_nxt = 1'b1;
                  end else begin
                    frame_nxt = frame - FRAME_W'(1);
                    dir_nxt   = DIR_DOWN;
                  end
                end else begin
                  frame_nxt = frame + FRAME_W'(1);
                end
              end else begin
                if (frame == '0) begin
                  frame_nxt = frame + FRAME_W'(1);
                  dir_nxt   = DIR_UP;
                  wrap_nxt  = 1'b1;
                end else begin
                  frame_nxt = frame - FRAME_W'(1);
                end
              end
            end
            MODE_ONESHOT: begin
              frame_tick_nxt = 1'b1;
              if (frame == cur_lim) begin
                // done stops the prescaler, so this wrap fires only once.
                done_nxt = 1'b1;
                wrap_nxt = 1'b1;
              end else begin
                frame_nxt = frame + FRAME_W'(1);
              end
            end
            default: begin
              // Hold: frame frozen, no pulses.
            end
          endcase
        end
      end
    end
  end

  // State registers; reset drops any pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      frame      <= '0;
      ani_cur    <= '0;
      dir        <= DIR_UP;
      cnt        <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      frame_tick <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
    end else begin
      frame      <= frame_nxt;
      ani_cur    <= ani_nxt;
      dir        <= dir_nxt;
      cnt        <= cnt_nxt;
      pend       <= pend_nxt;
      pend_v     <= pend_v_nxt;
      frame_tick <= frame_tick_nxt;
      wrap       <= wrap_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Self-checking bench for anim_frame_sequencer: directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_anim_frame_sequencer;

  localparam int ANI_W   = 6;
  localparam int FRAME_W = 6;
  localparam int PRESC_W = 24;
  localparam int OBS_W   = ANI_W + FRAME_W + 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               ena = 1'b0;
  logic               pause = 1'b0;
  logic [PRESC_W-1:0] presc_div = '0;
  logic [1:0]         mode = 2'b00;
  logic [ANI_W-1:0]   ani_req = '0;
  logic               ani_req_valid = 1'b0;
  logic               ani_req_ready;
  logic [ANI_W-1:0]   ani_cur;
  logic [FRAME_W-1:0] frame;
  logic               frame_tick;
  logic               wrap;
  logic               done;

  anim_frame_sequencer #(
    .ANI_W(ANI_W), .FRAME_W(FRAME_W), .PRESC_W(PRESC_W), .DEFAULT_LIMIT(63)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pause(pause), .presc_div(presc_div),
    .mode(mode), .ani_req(ani_req), .ani_req_valid(ani_req_valid),
    .ani_req_ready(ani_req_ready), .ani_cur(ani_cur), .frame(frame),
    .frame_tick(frame_tick), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  logic [OBS_W-1:0] obs;
  assign obs = {ani_req_ready, ani_cur, frame, frame_tick, wrap, done};

  // Expected outputs right after reset: ready=1, everything else 0.
  localparam logic [OBS_W-1:0] RESET_OBS = {1'b1, {(OBS_W-1){1'b0}}};

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int lim_tab[64];
  int m_frame, m_ani, m_cnt, m_pend;
  bit m_down, m_pv, m_done, m_ft, m_wr, m_acc;

  function automatic void fill(int lo, int hi, int v);
    for (int i = lo; i <= hi; i++) lim_tab[i] = v;
  endfunction

  function automatic void build_table();
    fill(0, 63, 63);
    fill(0, 0, 9);    fill(1, 1, 11);   fill(2, 6, 5);    fill(7, 7, 1);
    fill(8, 9, 3);    fill(10, 14, 1);  fill(15, 15, 3);  fill(16, 16, 4);
    fill(17, 17, 1);  fill(18, 22, 6);  fill(23, 23, 3);  fill(24, 27, 15);
    fill(28, 28, 31); fill(29, 29, 3);  fill(30, 30, 10); fill(31, 31, 31);
    fill(32, 32, 4);  fill(33, 33, 8);  fill(34, 40, 4);
  endfunction

  function automatic void model_reset();
    m_frame = 0; m_ani = 0; m_cnt = 0; m_pend = 0;
    m_down = 0; m_pv = 0; m_done = 0; m_ft = 0; m_wr = 0; m_acc = 0;
  endfunction

  function automatic logic [OBS_W-1:0] exp_vec();
    return {!m_pv, ANI_W'(m_ani), FRAME_W'(m_frame), m_ft, m_wr, m_done};
  endfunction

  // Advance one clock; the model computes the post-edge state from the
  // pre-edge inputs, outputs are then observed 1 time unit after the edge.
  task automatic step();
    int f, a, c, p, lim;
    bit dd, pv, dn, ft, wr, run, tk, sw;
    f = m_frame; a = m_ani; c = m_cnt; p = m_pend;
    dd = m_down; pv = m_pv; dn = m_done; ft = 0; wr = 0;
    m_acc = ani_req_valid && !m_pv;
    run = ena && !pause && !m_done;
    tk  = run && (m_cnt >= int'(presc_div));
    sw  = m_pv && (tk || m_done || mode == 2'b11);
    if (m_acc) begin pv = 1; p = int'(ani_req); end
    if (sw) begin
      a = m_pend; f = 0; dd = 0; dn = 0; c = 0; pv = 0; ft = 1;
    end else begin
      c = tk ? 0 : (run ? m_cnt + 1 : m_cnt);
      if (mode != 2'b10) dn = 0;
      if (mode != 2'b01) dd = 0;
      if (tk) begin
        lim = lim_tab[m_ani];
        if (m_frame > lim) begin
          f = 0; wr = 1; ft = 1;
        end else begin
          case (mode)
            2'b00: begin
              ft = 1;
              if (m_frame == lim) begin f = 0; wr = 1; end
              else f = m_frame + 1;
            end
            2'b01: begin
              ft = 1;
              if (!m_down) begin
                if (m_frame == lim) begin
                  if (lim == 0) wr = 1;
                  else begin f = m_frame - 1; dd = 1; end
                end else f = m_frame + 1;
              end else begin
                if (m_frame == 0) begin f = 1; dd = 0; wr = 1; end
                else f = m_frame - 1;
              end
            end
            2'b10: begin
              ft = 1;
              if (m_frame == lim) begin dn = 1; wr = 1; end
              else f = m_frame + 1;
            end
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    m_frame = f; m_ani = a; m_cnt = c; m_pend = p;
    m_down = dd; m_pv = pv; m_done = dn; m_ft = ft; m_wr = wr;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (obs !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, RESET_OBS);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_loop();
    int max_seen, wraps, last_tick, gap;
    max_seen = 0; wraps = 0; last_tick = -1; gap = 0;
    mode = 2'b00; presc_div = 2; ena = 1'b1; pause = 1'b0;
    ani_req = 0; ani_req_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      step();
      ani_req_valid = 1'b0;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL loop cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (int'(frame) > max_seen) max_seen = int'(frame);
      if (wrap) wraps++;
      if (frame_tick) begin
        if (last_tick >= 0) gap = i - last_tick;
        last_tick = i;
      end
    end
    n_checks++;
    if (max_seen != 9 || wraps == 0 || gap != 3) begin
      n_fail++;
      $display("FAIL loop_shape: max %0d wraps %0d gap %0d expected max 9 wraps>0 gap 3",
               max_seen, wraps, gap);
    end
  endtask

  task automatic test_pingpong();
    int max_seen, prev;
    bit turned;
    mode = 2'b01; presc_div = 0;
    ani_req = 7; ani_req_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      ani_req_valid = 1'b0;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL pingpong7 cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    ani_req = 24; ani_req_valid = 1'b1;
    max_seen = 0; prev = -1; turned = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      ani_req_valid = 1'b0;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL pingpong24 cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (ani_cur == 24 && int'(frame) > max_seen) max_seen = int'(frame);
      if (ani_cur == 24 && prev == 15 && frame == 14) turned = 1;
      prev = int'(frame);
    end
    n_checks++;
    if (max_seen != 15 || !turned) begin
      n_fail++;
      $display("FAIL pingpong_turn: max %0d turned %0d expected 15 and 1", max_seen, turned);
    end
  endtask

  task automatic test_oneshot();
    int wraps;
    wraps = 0;
    mode = 2'b10; presc_div = 0;
    ani_req = 16; ani_req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      ani_req_valid = 1'b0;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL oneshot cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (ani_cur == 16 && wrap) wraps++;
    end
    n_checks++;
    if (done !== 1'b1 || frame !== 4 || wraps != 1) begin
      n_fail++;
      $display("FAIL oneshot_end: done %0b frame %0d wraps %0d expected 1 4 1", done, frame, wraps);
    end
    ani_req = 3; ani_req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      ani_req_valid = 1'b0;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL oneshot_restart cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (ani_cur !== 3 || frame !== 0 || done !== 1'b0 || frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_switch: ani %0d frame %0d done %0b tick %0b expected 3 0 0 1",
               ani_cur, frame, done, frame_tick);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    mode = 2'b00; presc_div = 4;
    ani_req = 31; ani_req_valid = 1'b1;
    step();
    n_checks++;
    if (obs !== exp_vec() || ani_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected %h (ready low)", obs, exp_vec());
    end
    ani_req = 2;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_wait cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (m_acc) begin
        got = 1;
        ani_req_valid = 1'b0;
        n_checks++;
        if (ani_cur !== 31) begin
          n_fail++;
          $display("FAIL b2b_order: ani_cur %0d when second accepted, expected 31", ani_cur);
        end
      end
    end
    ani_req_valid = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL b2b_timeout: second request never accepted");
    end
    for (int i = 0; i < 15; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_after cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (ani_cur !== 2) begin
      n_fail++;
      $display("FAIL b2b_final: ani_cur %0d expected 2", ani_cur);
    end
  endtask

  task automatic test_collision();
    bit found;
    int max_seen;
    mode = 2'b00; presc_div = 3;
    ani_req = 7; ani_req_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      ani_req_valid = 1'b0;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL collide_setup cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (m_ani == 7 && m_frame == 1 && m_ft) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL collide_timeout: never reached frame==lim on ani 7");
    end
    ani_req = 50; ani_req_valid = 1'b1;
    step();
    ani_req_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL collide_wait cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (m_ft) found = 1;
    end
    n_checks++;
    if (ani_cur !== 50 || frame !== 0 || frame_tick !== 1'b1 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_switch: ani %0d frame %0d tick %0b wrap %0b expected 50 0 1 0",
               ani_cur, frame, frame_tick, wrap);
    end
    presc_div = 0;
    max_seen = 0;
    for (int i = 0; i < 140; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL default_lim cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (int'(frame) > max_seen) max_seen = int'(frame);
    end
    n_checks++;
    if (max_seen != 63) begin
      n_fail++;
      $display("FAIL default_lim_max: max frame %0d expected 63", max_seen);
    end
  endtask

  task automatic test_freeze();
    logic [FRAME_W-1:0] held;
    mode = 2'b00; presc_div = 1;
    for (int i = 0; i < 4; i++) step();
    for (int phase = 0; phase < 2; phase++) begin
      ena = (phase == 0) ? 1'b0 : 1'b1;
      pause = (phase == 1);
      held = frame;
      for (int i = 0; i < 10; i++) begin
        step();
        n_checks++;
        if (obs !== exp_vec()) begin
          n_fail++;
          $display("FAIL freeze%0d cyc %0d: got %h expected %h", phase, i, obs, exp_vec());
        end
      end
      n_checks++;
      if (frame !== held || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze%0d_hold: frame %0d tick %0b expected %0d 0", phase, frame, frame_tick, held);
      end
    end
    ena = 1'b1; pause = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL thaw cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    // Leave a request pending, then reset between clock edges.
    ani_req = 9; ani_req_valid = 1'b1;
    step();
    ani_req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== RESET_OBS) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs, RESET_OBS);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    presc_div = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      ena   = ($urandom_range(0, 9) != 0);
      pause = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) presc_div = PRESC_W'($urandom_range(0, 6));
      ani_req_valid = ($urandom_range(0, 9) == 0);
      ani_req = ANI_W'($urandom_range(0, 63));
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    ani_req_valid = 1'b0;
  endtask

  initial begin
    build_table();
    model_reset();
    test_reset();
    test_loop();
    test_pingpong();
    test_oneshot();
    test_back_to_back();
    test_collision();
    test_freeze();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
